link_receiver: RTL and testbench
================================

LINK_RECEIVER -- requirements
Module: link_receiver

Interface
REQ-001 Parameter ENC, default "TP", selects link encoding: "TP" is two-phase dual-rail, "FP" is four-phase dual-rail return-to-zero.
REQ-002 Parameter WIDTH, default 1, is the number of dual-rail data bits per link word.
REQ-003 Parameter SYNC_STAGES, default 2, is the synchronizer depth per rail; legal values are 2 or more.
REQ-004 Parameter FIFO_DEPTH, default 4, is the receive buffer depth in words; it shall be a power of 2 and at least 2.
REQ-005 The block has one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in  in  [WIDTH][2]  asynchronous dual-rail link; [i][1] is the true rail and [i][0] is the false rail.
REQ-009 ack_o  out  1  link acknowledge to the sender; it toggles in TP mode and is a level in FP mode.
REQ-010 data_o  out  WIDTH  head-of-FIFO decoded word.
REQ-011 valid_o  out  1  data_o holds a valid word.
REQ-012 ready_i  in  1  consumer accepts the word; a pop occurs when valid_o and ready_i are both high.
REQ-013 level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 err_o  out  1  sticky protocol-violation flag.

Function
REQ-015 Each rail shall pass through a SYNC_STAGES-flop synchronizer; all decode logic uses only synchronized rails (s).
REQ-016 TP mode: a per-rail reference register ref shall hold the last acknowledged rail values.
- Bit i is complete when exactly one of s[i][1]^ref[i][1] and s[i][0]^ref[i][0] is 1.
- Decoded bit = s[i][1]^ref[i][1].
REQ-017 TP mode: when all bits are complete and the FIFO is not full, on the next edge:
- push the decoded word;
- set ref to s;
- toggle ack_o.
REQ-018 TP mode: if any bit has both rails differing from ref, the FSM enters ERROR.
REQ-019 FP mode FSM has states WAIT_DATA, WAIT_NULL and ERROR.
- WAIT_DATA: when every bit has exactly one rail high and the FIFO is not full, push the word (bit = s[i][1]), set ack_o to 1, go to WAIT_NULL.
- WAIT_NULL: when all rails are 0, set ack_o to 0, go to WAIT_DATA.
REQ-020 FP mode: any bit with both rails high, in either state, sends the FSM to ERROR.
REQ-021 ERROR sets err_o to 1 and freezes ack_o, ref and FSM state; only reset exits ERROR. FIFO pops continue.
REQ-022 Partial words (some bits complete, others not) shall cause no action; the block keeps waiting.
REQ-023 Backpressure: while the FIFO is full, a complete word is neither pushed nor acknowledged; it is accepted on the first edge at which the FIFO is not full.
REQ-024 Push full-check uses the registered level. A simultaneous pop while full does not admit a push that cycle; the push lands one edge later.
REQ-025 Simultaneous push and pop when not full leaves level_o unchanged and preserves FIFO order.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH. data_o is registered or FIFO-read, and is stable while valid_o is high and ready_i is low.
REQ-027 Latency: ack_o and valid_o update exactly SYNC_STAGES+1 rising edges after the edge that first samples the completing rail transition, with an empty FIFO.

Reset
REQ-028 When rst is low, the following clear immediately and asynchronously:
- synchronizers, ref, ack_o, valid_o, err_o;
- level_o = 0, FIFO pointers = 0;
- FSM = WAIT_DATA.
REQ-029 Reset mid-word discards any in-flight and buffered words; the sender's rails shall also return to 0 for a consistent restart.
REQ-030 Reset release shall be synchronized internally; the first state change occurs no earlier than the second rising edge after rst rises.

Verification
REQ-031 TP, WIDTH=4, FIFO_DEPTH=4: sender toggles the rails for 0xA then 0x5 with ready_i=1 -> data_o shows 0xA then 0x5, ack_o toggles 0->1->0, each toggle SYNC_STAGES+1 edges after the rails change.
REQ-032 FP, WIDTH=4: apply 0x3 and hold, then all-zero -> push 0x3 and ack_o=1; after the null, ack_o=0 with state WAIT_DATA.
REQ-033 TP, ready_i=0, send 5 words -> level_o=4 and the 5th word is not acknowledged; pulse ready_i for 1 cycle -> the 5th word is pushed the following edge after the pop and ack_o toggles.
REQ-034 FP: drive bit 2 with both rails high -> err_o=1 and ack_o frozen; buffered words still pop; only rst low clears err_o.
REQ-035 TP: bits change one at a time, 3 cycles apart -> no push until the last bit completes, then exactly one push.
REQ-036 Assert rst low with 2 words buffered and a word half-sent -> level_o=0, valid_o=0, ack_o=0 immediately; after a rail reset and release, a fresh 0x9 is received correctly.

Source files
------------

// File: rtl/link_receiver_if.sv
// Signal bundle between a dual-rail link sender/consumer pair and link_receiver.
interface link_receiver_if #(
  parameter int WIDTH      = 1,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0][1:0] in;
  logic                  ack_o;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [LW-1:0]         level_o;
  logic                  err_o;

  modport master (output in, ready_i, input ack_o, data_o, valid_o, level_o, err_o);
  modport slave  (input in, ready_i, output ack_o, data_o, valid_o, level_o, err_o);
endinterface

// File: rtl/link_receiver.sv
// Dual-rail asynchronous link receiver (two-phase or four-phase RTZ) feeding a
// small word FIFO toward a synchronous consumer.
//
// state     | meaning
// WAIT_DATA | waiting for a complete word (TP: the only running state)
// WAIT_NULL | FP only: word acknowledged, waiting for all rails to return to 0
// ERROR     | protocol violation seen; ack/ref/state frozen until reset
module link_receiver #(
  parameter     ENC         = "TP",
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  link_receiver_if.slave lnk
);
  localparam bit FP_MODE = (ENC == "FP");
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    WAIT_NULL = 2'd1,
    ERROR     = 2'd2
  } state_t;

  logic [1:0] rst_pipe_q;
  logic       rst_int_b;

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0] s;
  logic [WIDTH-1:0][1:0] ref_q, ref_d;

  logic [WIDTH-1:0] bit_done, bit_bad, word_val;
  logic             word_done, word_bad, all_null;

  state_t state_q, state_d;
  logic   ack_q, ack_d;
  logic   push, pop, full;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;

  // Assert immediately, release two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe_q <= '0;
    else      rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end

  assign rst_int_b = rst_pipe_q[1];

  always_ff @(posedge clk or negedge rst_int_b) begin
    if (!rst_int_b) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], lnk.in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // TP compares against the last acknowledged rails; FP reads the rails directly.
  always_comb begin
    bit_done = '0;
    bit_bad  = '0;
    word_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (FP_MODE) begin
        bit_done[i] = s[i][1] ^ s[i][0];
        bit_bad[i]  = s[i][1] & s[i][0];
        word_val[i] = s[i][1];
      end else begin
        bit_done[i] = (s[i][1] ^ ref_q[i][1]) ^ (s[i][0] ^ ref_q[i][0]);
        bit_bad[i]  = (s[i][1] ^ ref_q[i][1]) & (s[i][0] ^ ref_q[i][0]);
        word_val[i] = s[i][1] ^ ref_q[i][1];
      end
    end
  end

  assign word_done = &bit_done;
  assign word_bad  = |bit_bad;
  assign all_null  = (s == '0);

  always_ff @(posedge clk or negedge rst_int_b) begin
    if (!rst_int_b) begin
      state_q <= WAIT_DATA;
      ack_q   <= 1'b0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ref_q   <= ref_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    ref_d   = ref_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (word_bad) begin
          state_d = ERROR;
        end else if (word_done && !full) begin
          push  = 1'b1;
          ref_d = s;
          if (FP_MODE) begin
            ack_d   = 1'b1;
            state_d = WAIT_NULL;
          end else begin
            ack_d = ~ack_q;
          end
        end
      end
      WAIT_NULL: begin
        if (word_bad) begin
          state_d = ERROR;
        end else if (all_null) begin
          ack_d   = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // Full is judged on the registered level, so a pop while full delays the push one edge.
  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = (level_q != '0) && lnk.ready_i;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_val;
  end

  always_ff @(posedge clk or negedge rst_int_b) begin
    if (!rst_int_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign lnk.ack_o   = ack_q;
  assign lnk.data_o  = mem_q[rd_ptr_q];
  assign lnk.valid_o = (level_q != '0);
  assign lnk.level_o = level_q;
  assign lnk.err_o   = (state_q == ERROR);
endmodule

// File: tb/tb_link_receiver.sv
// Randomized bench for link_receiver: a TP and an FP instance driven by
// behavioural senders, checked against a word-queue model of the link.
module tb_link_receiver;
  localparam int W   = 4;
  localparam int D   = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  link_receiver_if #(.WIDTH(W), .FIFO_DEPTH(D)) t_if ();
  link_receiver_if #(.WIDTH(W), .FIFO_DEPTH(D)) f_if ();

  link_receiver #(.ENC("TP"), .WIDTH(W), .SYNC_STAGES(SS), .FIFO_DEPTH(D)) dut_tp (
    .clk(clk), .rst(rst), .lnk(t_if.slave));
  link_receiver #(.ENC("FP"), .WIDTH(W), .SYNC_STAGES(SS), .FIFO_DEPTH(D)) dut_fp (
    .clk(clk), .rst(rst), .lnk(f_if.slave));

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0][1:0] tp_rails;
  logic              tp_ack_exp;
  logic [W-1:0]      tp_q[$];
  logic [W-1:0]      fp_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges from a rail change (first edge = 1) until ack reaches exp.
  task automatic wait_ack(input bit fp, input logic exp, input string tag);
    int   edges;
    logic a;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      a = fp ? f_if.ack_o : t_if.ack_o;
    end while (a !== exp && edges < 40);
    chk_eq({tag, "_ack"}, 32'(a), 32'(exp));
    chk_eq({tag, "_lat"}, 32'(edges), 32'(LAT));
  endtask

  task automatic tp_drive(input logic [W-1:0] w);
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      if (w[i]) tp_rails[i][1] = ~tp_rails[i][1];
      else      tp_rails[i][0] = ~tp_rails[i][0];
    end
    t_if.in = tp_rails;
  endtask

  task automatic tp_send(input logic [W-1:0] w, input string tag);
    tp_drive(w);
    tp_ack_exp = ~tp_ack_exp;
    wait_ack(1'b0, tp_ack_exp, tag);
  endtask

  task automatic fp_send(input logic [W-1:0] w, input string tag);
    logic [W-1:0][1:0] r;
    @(negedge clk);
    for (int i = 0; i < W; i++) r[i] = {w[i], ~w[i]};
    f_if.in = r;
    wait_ack(1'b1, 1'b1, tag);
  endtask

  task automatic fp_null(input string tag);
    @(negedge clk);
    f_if.in = '0;
    wait_ack(1'b1, 1'b0, tag);
  endtask

  // Pops every modelled word and compares it with the FIFO head.
  task automatic drain(input bit fp, input string tag);
    logic [W-1:0] exp_w;
    int           guard;
    guard = 0;
    while (((fp ? fp_q.size() : tp_q.size()) > 0) && guard < 16) begin
      @(negedge clk);
      if (fp) begin
        f_if.ready_i = 1'b1;
        exp_w = fp_q.pop_front();
        chk_eq({tag, "_valid"}, 32'(f_if.valid_o), 32'd1);
        chk_eq({tag, "_data"}, 32'(f_if.data_o), 32'(exp_w));
      end else begin
        t_if.ready_i = 1'b1;
        exp_w = tp_q.pop_front();
        chk_eq({tag, "_valid"}, 32'(t_if.valid_o), 32'd1);
        chk_eq({tag, "_data"}, 32'(t_if.data_o), 32'(exp_w));
      end
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    t_if.ready_i = 1'b0;
    f_if.ready_i = 1'b0;
    chk_eq({tag, "_empty"}, 32'(fp ? f_if.level_o : t_if.level_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] w5;
    int           n_valid;

    t_if.in      = '0;
    f_if.in      = '0;
    t_if.ready_i = 1'b0;
    f_if.ready_i = 1'b0;
    tp_rails     = '0;
    tp_ack_exp   = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("rst_tp_ack", 32'(t_if.ack_o), 32'd0);
    chk_eq("rst_tp_valid", 32'(t_if.valid_o), 32'd0);
    chk_eq("rst_tp_level", 32'(t_if.level_o), 32'd0);
    chk_eq("rst_tp_err", 32'(t_if.err_o), 32'd0);
    chk_eq("rst_fp_ack", 32'(f_if.ack_o), 32'd0);
    chk_eq("rst_fp_err", 32'(f_if.err_o), 32'd0);

    // TP streaming with a ready consumer: 0xA, 0x5, then random words.
    @(negedge clk);
    t_if.ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      w = (k == 0) ? 4'hA : (k == 1) ? 4'h5 : W'($urandom_range(0, 15));
      tp_send(w, "tp_stream");
      chk_eq("tp_stream_valid", 32'(t_if.valid_o), 32'd1);
      chk_eq("tp_stream_data", 32'(t_if.data_o), 32'(w));
      chk_eq("tp_stream_level", 32'(t_if.level_o), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    t_if.ready_i = 1'b0;
    chk_eq("tp_stream_drained", 32'(t_if.level_o), 32'd0);

    // Backpressure: four words fill the FIFO, the fifth waits for a pop.
    for (int k = 0; k < 4; k++) begin
      w = W'($urandom_range(0, 15));
      tp_send(w, "tp_fill");
      tp_q.push_back(w);
      chk_eq("tp_fill_level", 32'(t_if.level_o), 32'(tp_q.size()));
    end
    w5 = W'($urandom_range(0, 15));
    tp_drive(w5);
    repeat (10) @(posedge clk);
    #1;
    chk_eq("tp_full_noack", 32'(t_if.ack_o), 32'(tp_ack_exp));
    chk_eq("tp_full_level", 32'(t_if.level_o), 32'd4);
    chk_eq("tp_full_head_stable", 32'(t_if.data_o), 32'(tp_q[0]));
    @(negedge clk);
    t_if.ready_i = 1'b1;
    @(posedge clk); #1;
    void'(tp_q.pop_front());
    chk_eq("tp_pop_level", 32'(t_if.level_o), 32'd3);
    chk_eq("tp_pop_noack", 32'(t_if.ack_o), 32'(tp_ack_exp));
    @(negedge clk);
    t_if.ready_i = 1'b0;
    @(posedge clk); #1;
    tp_ack_exp = ~tp_ack_exp;
    tp_q.push_back(w5);
    chk_eq("tp_late_ack", 32'(t_if.ack_o), 32'(tp_ack_exp));
    chk_eq("tp_late_level", 32'(t_if.level_o), 32'd4);
    drain(1'b0, "tp_drain");

    // Bits arrive one at a time, three cycles apart.
    w = W'($urandom_range(0, 15));
    @(negedge clk);
    t_if.ready_i = 1'b1;
    for (int b = 0; b < W; b++) begin
      @(negedge clk);
      if (w[b]) tp_rails[b][1] = ~tp_rails[b][1];
      else      tp_rails[b][0] = ~tp_rails[b][0];
      t_if.in = tp_rails;
      if (b < W - 1) begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("tp_partial_noack", 32'(t_if.ack_o), 32'(tp_ack_exp));
        chk_eq("tp_partial_nopush", 32'(t_if.valid_o), 32'd0);
      end
    end
    tp_ack_exp = ~tp_ack_exp;
    wait_ack(1'b0, tp_ack_exp, "tp_partial");
    chk_eq("tp_partial_data", 32'(t_if.data_o), 32'(w));
    n_valid = int'(t_if.valid_o);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_valid += int'(t_if.valid_o);
    end
    chk_eq("tp_partial_one_push", 32'(n_valid), 32'd1);
    @(negedge clk);
    t_if.ready_i = 1'b0;

    // FP: 0x3 then random words, each followed by a null.
    @(negedge clk);
    f_if.ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 4'h3 : W'($urandom_range(0, 15));
      fp_send(w, "fp_data");
      chk_eq("fp_data_valid", 32'(f_if.valid_o), 32'd1);
      chk_eq("fp_data_word", 32'(f_if.data_o), 32'(w));
      fp_null("fp_null");
      chk_eq("fp_err_clear", 32'(f_if.err_o), 32'd0);
    end
    @(negedge clk);
    f_if.ready_i = 1'b0;

    // FP protocol error with two words buffered.
    for (int k = 0; k < 2; k++) begin
      w = W'($urandom_range(0, 15));
      fp_send(w, "fp_buf");
      fp_null("fp_buf_null");
      fp_q.push_back(w);
    end
    chk_eq("fp_buf_level", 32'(f_if.level_o), 32'd2);
    @(negedge clk);
    f_if.in = '0;
    f_if.in[2] = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("fp_err_set", 32'(f_if.err_o), 32'd1);
    chk_eq("fp_err_ack", 32'(f_if.ack_o), 32'd0);
    @(negedge clk);
    f_if.in = '0;
    f_if.in[0] = 2'b10;
    f_if.in[1] = 2'b01;
    f_if.in[2] = 2'b01;
    f_if.in[3] = 2'b01;
    repeat (8) @(posedge clk);
    #1;
    chk_eq("fp_err_frozen_ack", 32'(f_if.ack_o), 32'd0);
    chk_eq("fp_err_no_push", 32'(f_if.level_o), 32'd2);
    drain(1'b1, "fp_err_drain");
    chk_eq("fp_err_sticky", 32'(f_if.err_o), 32'd1);

    // Reset with two TP words buffered and a third half sent.
    for (int k = 0; k < 2; k++) begin
      w = W'($urandom_range(0, 15));
      tp_send(w, "tp_prerst");
    end
    chk_eq("tp_prerst_level", 32'(t_if.level_o), 32'd2);
    chk_eq("tp_prerst_ack", 32'(t_if.ack_o), 32'd1);
    @(negedge clk);
    tp_rails[0][1] = ~tp_rails[0][1];
    tp_rails[1][0] = ~tp_rails[1][0];
    t_if.in = tp_rails;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("rst_mid_level", 32'(t_if.level_o), 32'd0);
    chk_eq("rst_mid_valid", 32'(t_if.valid_o), 32'd0);
    chk_eq("rst_mid_ack", 32'(t_if.ack_o), 32'd0);
    chk_eq("rst_mid_fp_err", 32'(f_if.err_o), 32'd0);
    tp_q.delete();
    fp_q.delete();
    tp_rails   = '0;
    tp_ack_exp = 1'b0;
    t_if.in    = '0;
    f_if.in    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    t_if.ready_i = 1'b1;
    f_if.ready_i = 1'b1;
    tp_send(4'h9, "tp_restart");
    chk_eq("tp_restart_data", 32'(t_if.data_o), 32'h9);
    chk_eq("tp_restart_level", 32'(t_if.level_o), 32'd1);
    fp_send(4'h9, "fp_restart");
    chk_eq("fp_restart_data", 32'(f_if.data_o), 32'h9);
    fp_null("fp_restart_null");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
